// File: rtl/sd_reg_access_arbiter_if.sv
// Signal bundle between the SD register-access arbiter, the host bus,
// the command engine and the single-port register bank.
interface sd_reg_access_arbiter_if #(
  parameter int ADR_W  = 5,
  parameter int DATA_W = 128
);
  // host bus
  logic              host_req;
  logic              host_we;
  logic [ADR_W-1:0]  host_adr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_ack;
  logic [DATA_W-1:0] host_rdata;
  logic              host_err;
  // command engine
  logic              command_complete;
  logic [DATA_W-1:0] response_i;
  logic [15:0]       normal_interrupt_status_i;
  logic [15:0]       error_interrupt_status_i;
  logic              core_busy;
  logic              core_ovf;
  // register bank port
  logic [ADR_W-1:0]  adr_o;
  logic              reg_write_en;
  logic              reg_read_en;
  logic [DATA_W-1:0] data_o;
  logic [DATA_W-1:0] reg_rdata;

  // environment side: host, command engine and bank
  modport master (
    output host_req, host_we, host_adr, host_wdata,
    output command_complete, response_i,
    output normal_interrupt_status_i, error_interrupt_status_i,
    output reg_rdata,
    input  host_ack, host_rdata, host_err, core_busy, core_ovf,
    input  adr_o, reg_write_en, reg_read_en, data_o
  );

  // arbiter side
  modport slave (
    input  host_req, host_we, host_adr, host_wdata,
    input  command_complete, response_i,
    input  normal_interrupt_status_i, error_interrupt_status_i,
    input  reg_rdata,
    output host_ack, host_rdata, host_err, core_busy, core_ovf,
    output adr_o, reg_write_en, reg_read_en, data_o
  );
endinterface

// File: rtl/sd_reg_access_arbiter.sv
// Shares the single-port SD host register bank between the host bus and the
// command engine. Each command_complete snapshot is posted as two writes
// (response word, then interrupt status); host and core alternate when both wait.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// IDLE         | no bank access; arbitrate host request vs pending core event
// HOST_WR      | host write strobe + ack
// HOST_RD      | host read strobe
// HOST_RD_WAIT | bank data returns; host ack with read data
// HOST_ERR     | host address out of range; ack + err, no bank access
// CORE_RESP    | write captured response word to RESP_ADR
// CORE_STAT    | write captured interrupt status to STAT_ADR, release snapshot
module sd_reg_access_arbiter #(
  parameter int ADR_W    = 5,
  parameter int DATA_W   = 128,
  parameter int MAX_ADR  = 15,
  parameter int RESP_ADR = 4,
  parameter int STAT_ADR = 12
) (
  input logic                    clock,
  input logic                    reset,
  sd_reg_access_arbiter_if.slave bus
);

  localparam logic [ADR_W-1:0] MAX_ADR_L  = ADR_W'(MAX_ADR);
  localparam logic [ADR_W-1:0] RESP_ADR_L = ADR_W'(RESP_ADR);
  localparam logic [ADR_W-1:0] STAT_ADR_L = ADR_W'(STAT_ADR);

  typedef enum logic [2:0] {
    IDLE,
    HOST_WR,
    HOST_RD,
    HOST_RD_WAIT,
    HOST_ERR,
    CORE_RESP,
    CORE_STAT
  } state_t;

  state_t            state_q, state_d;
  logic              pend_q, pend_d;
  logic              ovf_q, ovf_d;
  logic              last_host_q, last_host_d;   // 1 = host had the last grant
  logic [DATA_W-1:0] resp_q, resp_d;
  logic [31:0]       stat_q, stat_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              stat_clear;

  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic              we_q, we_d;
  logic              re_q, re_d;
  logic [ADR_W-1:0]  adr_q, adr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              busy_q, busy_d;

  // Next state, snapshot capture, and output values decoded from the upcoming state.
  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    ovf_d       = ovf_q;
    last_host_d = last_host_q;
    resp_d      = resp_q;
    stat_d      = stat_q;
    rdata_d     = rdata_q;
    ack_d       = 1'b0;
    err_d       = 1'b0;
    we_d        = 1'b0;
    re_d        = 1'b0;
    adr_d       = '0;
    data_d      = '0;
    stat_clear  = (state_q == CORE_STAT);

    // The snapshot slot frees up in CORE_STAT, so an event landing there is kept.
    if (bus.command_complete) begin
      if (!pend_q || stat_clear) begin
        resp_d = bus.response_i;
        stat_d = {bus.error_interrupt_status_i, bus.normal_interrupt_status_i};
        pend_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (stat_clear) begin
      pend_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (pend_q && (!bus.host_req || last_host_q)) begin
          state_d = CORE_RESP;
        end else if (bus.host_req) begin
          if (bus.host_adr > MAX_ADR_L) state_d = HOST_ERR;
          else if (bus.host_we)         state_d = HOST_WR;
          else                          state_d = HOST_RD;
        end
      end
      HOST_WR: begin
        last_host_d = 1'b1;
        state_d     = IDLE;
      end
      HOST_RD: state_d = HOST_RD_WAIT;
      HOST_RD_WAIT: begin
        rdata_d     = bus.reg_rdata;
        last_host_d = 1'b1;
        state_d     = IDLE;
      end
      HOST_ERR: begin
        last_host_d = 1'b1;
        state_d     = IDLE;
      end
      CORE_RESP: state_d = CORE_STAT;
      CORE_STAT: begin
        last_host_d = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the state being entered, so they line up
    // with that state's cycle.
    case (state_d)
      HOST_WR: begin
        adr_d  = bus.host_adr;
        data_d = bus.host_wdata;
        we_d   = 1'b1;
        ack_d  = 1'b1;
      end
      HOST_RD: begin
        adr_d = bus.host_adr;
        re_d  = 1'b1;
      end
      HOST_RD_WAIT: ack_d = 1'b1;
      HOST_ERR: begin
        ack_d = 1'b1;
        err_d = 1'b1;
      end
      CORE_RESP: begin
        adr_d  = RESP_ADR_L;
        data_d = resp_q;
        we_d   = 1'b1;
      end
      CORE_STAT: begin
        adr_d  = STAT_ADR_L;
        data_d = DATA_W'(stat_q);
        we_d   = 1'b1;
      end
      default: ;
    endcase

    busy_d = pend_d || (state_d == CORE_RESP) || (state_d == CORE_STAT);
  end

  // FSM state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Snapshot, arbitration history and registered bank/host outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pend_q      <= 1'b0;
      ovf_q       <= 1'b0;
      last_host_q <= 1'b0;
      resp_q      <= '0;
      stat_q      <= '0;
      rdata_q     <= '0;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      we_q        <= 1'b0;
      re_q        <= 1'b0;
      adr_q       <= '0;
      data_q      <= '0;
      busy_q      <= 1'b0;
    end else begin
      pend_q      <= pend_d;
      ovf_q       <= ovf_d;
      last_host_q <= last_host_d;
      resp_q      <= resp_d;
      stat_q      <= stat_d;
      rdata_q     <= rdata_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
      we_q        <= we_d;
      re_q        <= re_d;
      adr_q       <= adr_d;
      data_q      <= data_d;
      busy_q      <= busy_d;
    end
  end

  // Bank data only arrives in the ack cycle, so it is passed straight through
  // there and the captured copy is held afterwards.
  assign bus.host_rdata   = (state_q == HOST_RD_WAIT) ? bus.reg_rdata : rdata_q;
  assign bus.host_ack     = ack_q;
  assign bus.host_err     = err_q;
  assign bus.core_busy    = busy_q;
  assign bus.core_ovf     = ovf_q;
  assign bus.adr_o        = adr_q;
  assign bus.reg_write_en = we_q;
  assign bus.reg_read_en  = re_q;
  assign bus.data_o       = data_q;

endmodule
